// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//   Shares the single-port data memory between the CPU MEM stage (port 0) and
//   the debug/loader port (port 1). One transaction is in flight at a time; a
//   round-robin pointer settles collisions, and the granted port loses priority
//   on the next collision. The pipeline is stalled while a CPU access is pending.
//
//   Optional feature: define DMEM_ARB_TIMEOUT_EN to abort a transaction that
//   receives no mem_ack_i within TIMEOUT BUSY cycles (err_o pulses, done_o is
//   given with zero read data). Without the macro BUSY waits indefinitely and
//   err_o is constant 0.
//
// Parameters
//   AW       address width
//   DW       data width
//   TIMEOUT  BUSY cycles without ack before abort (>= 2, macro build only)
//
// Ports
//   clk_i, rst_i              clock; synchronous active-low reset
//   cpu_req/we/addr/wdata_i   CPU request, held stable until cpu_done_o
//   cpu_rdata_o, cpu_done_o   CPU read data (held) and one-cycle completion
//   cpu_stall_o               cpu_req_i & ~cpu_done_o, to PC/IFID/IDEX hold
//   dbg_*                     same as cpu_* for the debug/loader port
//   mem_req/we/addr/wdata_o   latched request to memory, req held until ack
//   mem_rdata_i, mem_ack_i    memory read data and one-cycle completion
//   busy_o                    1 while a transaction is in flight
//   err_o                     one-cycle timeout pulse
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          cpu_req_i,
  input  logic          cpu_we_i,
  input  logic [AW-1:0] cpu_addr_i,
  input  logic [DW-1:0] cpu_wdata_i,
  output logic [DW-1:0] cpu_rdata_o,
  output logic          cpu_done_o,
  output logic          cpu_stall_o,
  input  logic          dbg_req_i,
  input  logic          dbg_we_i,
  input  logic [AW-1:0] dbg_addr_i,
  input  logic [DW-1:0] dbg_wdata_i,
  output logic [DW-1:0] dbg_rdata_o,
  output logic          dbg_done_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i,
  input  logic          mem_ack_i,
  output logic          busy_o,
  output logic          err_o
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t        state_r, state_nxt_s;
  logic          rr_r, rr_nxt_s;         // port that wins the next collision
  logic          grant_r, grant_nxt_s;   // owner of the in-flight transaction
  logic          mem_req_r, mem_req_nxt_s;
  logic          mem_we_r, mem_we_nxt_s;
  logic [AW-1:0] mem_addr_r, mem_addr_nxt_s;
  logic [DW-1:0] mem_wdata_r, mem_wdata_nxt_s;
  logic          cpu_done_r, cpu_done_nxt_s;
  logic          dbg_done_r, dbg_done_nxt_s;
  logic [DW-1:0] cpu_rdata_r, cpu_rdata_nxt_s;
  logic [DW-1:0] dbg_rdata_r, dbg_rdata_nxt_s;
  logic          err_r, err_nxt_s;

  logic          cpu_req_s;
  logic          dbg_req_s;
  logic          pick_s;
  logic          expire_s;
  logic          finish_s;
  logic [DW-1:0] ret_data_s;

  // A requester still holds req during its done cycle; masking stops that
  // stale request from launching a duplicate transaction.
  assign cpu_req_s = cpu_req_i & ~cpu_done_r;
  assign dbg_req_s = dbg_req_i & ~dbg_done_r;

  // Single requester wins outright; on a collision the pointer decides.
  assign pick_s = (cpu_req_s && dbg_req_s) ? rr_r : dbg_req_s;

  assign finish_s   = mem_ack_i | expire_s;
  // Writes and aborted transactions return zero data.
  assign ret_data_s = (mem_ack_i && !mem_we_r) ? mem_rdata_i : {DW{1'b0}};

  // A limit below 2 leaves no BUSY cycle to count and is not a legal setting.
  if (TIMEOUT < 2) begin : g_timeout_too_small
  end

`ifdef DMEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT);

  logic [CNT_W-1:0] tmo_cnt_r, tmo_cnt_nxt_s;

  // Expiry only counts when the ack is absent: an ack on the last cycle wins.
  assign expire_s = (state_r == ST_BUSY) && !mem_ack_i &&
                    (tmo_cnt_r == CNT_W'(TIMEOUT - 1));

  // Watchdog next value: zero outside BUSY, +1 per BUSY cycle without ack.
  always_comb begin
    tmo_cnt_nxt_s = tmo_cnt_r;
    if (state_r != ST_BUSY) begin
      tmo_cnt_nxt_s = {CNT_W{1'b0}};
    end else if (!mem_ack_i && !expire_s) begin
      tmo_cnt_nxt_s = tmo_cnt_r + CNT_W'(1);
    end else begin
      tmo_cnt_nxt_s = tmo_cnt_r;
    end
  end

  // Watchdog counter register.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      tmo_cnt_r <= {CNT_W{1'b0}};
    end else begin
      tmo_cnt_r <= tmo_cnt_nxt_s;
    end
  end
`else
  assign expire_s = 1'b0;
`endif

  // Next-state and next-output logic for the arbitration FSM.
  always_comb begin
    state_nxt_s     = state_r;
    rr_nxt_s        = rr_r;
    grant_nxt_s     = grant_r;
    mem_req_nxt_s   = mem_req_r;
    mem_we_nxt_s    = mem_we_r;
    mem_addr_nxt_s  = mem_addr_r;
    mem_wdata_nxt_s = mem_wdata_r;
    cpu_done_nxt_s  = 1'b0;
    dbg_done_nxt_s  = 1'b0;
    cpu_rdata_nxt_s = cpu_rdata_r;
    dbg_rdata_nxt_s = dbg_rdata_r;
    err_nxt_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cpu_req_s || dbg_req_s) begin
          state_nxt_s   = ST_BUSY;
          grant_nxt_s   = pick_s;
          rr_nxt_s      = ~pick_s;
          mem_req_nxt_s = 1'b1;
          if (pick_s) begin
            mem_we_nxt_s    = dbg_we_i;
            mem_addr_nxt_s  = dbg_addr_i;
            mem_wdata_nxt_s = dbg_wdata_i;
          end else begin
            mem_we_nxt_s    = cpu_we_i;
            mem_addr_nxt_s  = cpu_addr_i;
            mem_wdata_nxt_s = cpu_wdata_i;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (finish_s) begin
          state_nxt_s   = ST_IDLE;
          mem_req_nxt_s = 1'b0;
          err_nxt_s     = expire_s;
          if (grant_r) begin
            dbg_done_nxt_s  = 1'b1;
            dbg_rdata_nxt_s = ret_data_s;
          end else begin
            cpu_done_nxt_s  = 1'b1;
            cpu_rdata_nxt_s = ret_data_s;
          end
        end else begin
          state_nxt_s = ST_BUSY;
        end
      end
      default: begin
        state_nxt_s   = ST_IDLE;
        mem_req_nxt_s = 1'b0;
      end
    endcase
  end

  // State and registered-output flops; reset aborts any transaction in flight.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_r     <= ST_IDLE;
      rr_r        <= 1'b0;
      grant_r     <= 1'b0;
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= {AW{1'b0}};
      mem_wdata_r <= {DW{1'b0}};
      cpu_done_r  <= 1'b0;
      dbg_done_r  <= 1'b0;
      cpu_rdata_r <= {DW{1'b0}};
      dbg_rdata_r <= {DW{1'b0}};
      err_r       <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      rr_r        <= rr_nxt_s;
      grant_r     <= grant_nxt_s;
      mem_req_r   <= mem_req_nxt_s;
      mem_we_r    <= mem_we_nxt_s;
      mem_addr_r  <= mem_addr_nxt_s;
      mem_wdata_r <= mem_wdata_nxt_s;
      cpu_done_r  <= cpu_done_nxt_s;
      dbg_done_r  <= dbg_done_nxt_s;
      cpu_rdata_r <= cpu_rdata_nxt_s;
      dbg_rdata_r <= dbg_rdata_nxt_s;
      err_r       <= err_nxt_s;
    end
  end

  assign cpu_rdata_o = cpu_rdata_r;
  assign cpu_done_o  = cpu_done_r;
  assign cpu_stall_o = cpu_req_i & ~cpu_done_r;
  assign dbg_rdata_o = dbg_rdata_r;
  assign dbg_done_o  = dbg_done_r;
  assign mem_req_o   = mem_req_r;
  assign mem_we_o    = mem_we_r;
  assign mem_addr_o  = mem_addr_r;
  assign mem_wdata_o = mem_wdata_r;
  assign busy_o      = (state_r == ST_BUSY);
  assign err_o       = err_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//   Directed bench for dmem_arbiter. Requesters and the memory responder are
//   small driver processes fed from queues; a transaction-level model predicts
//   every output and is compared on each falling edge, and the directed tests
//   add literal expectations for latency, data and arbitration order.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int TIMEOUT = 4;
`ifdef DMEM_ARB_TIMEOUT_EN
  localparam bit TMO_ON = 1'b1;
`else
  localparam bit TMO_ON = 1'b0;
`endif
  localparam logic [31:0] NOISE = 32'h0BAD_F00D;

  logic          clk = 1'b0;
  logic          rst_i = 1'b0;
  logic          cpu_req_i = 1'b0, cpu_we_i = 1'b0;
  logic [AW-1:0] cpu_addr_i = '0;
  logic [DW-1:0] cpu_wdata_i = '0;
  logic [DW-1:0] cpu_rdata_o;
  logic          cpu_done_o, cpu_stall_o;
  logic          dbg_req_i = 1'b0, dbg_we_i = 1'b0;
  logic [AW-1:0] dbg_addr_i = '0;
  logic [DW-1:0] dbg_wdata_i = '0;
  logic [DW-1:0] dbg_rdata_o;
  logic          dbg_done_o;
  logic          mem_req_o, mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [DW-1:0] mem_rdata_i = NOISE;
  logic          mem_ack_i = 1'b0;
  logic          busy_o, err_o;

  dmem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
    .cpu_wdata_i(cpu_wdata_i), .cpu_rdata_o(cpu_rdata_o), .cpu_done_o(cpu_done_o),
    .cpu_stall_o(cpu_stall_o),
    .dbg_req_i(dbg_req_i), .dbg_we_i(dbg_we_i), .dbg_addr_i(dbg_addr_i),
    .dbg_wdata_i(dbg_wdata_i), .dbg_rdata_o(dbg_rdata_o), .dbg_done_o(dbg_done_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
    .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory contents as the responder serves them.
  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a == 32'h0000_0010) ? 32'hDEAD_BEEF : ((a ^ 32'h5A5A_0000) + 32'h0000_1111);
  endfunction

  // ---------------- requester drivers ----------------
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  req_t cpu_q[$];
  req_t dbg_q[$];
  bit   cpu_act = 1'b0;
  bit   dbg_act = 1'b0;

  task automatic push(input bit port, input logic we, input logic [31:0] a, input logic [31:0] d);
    req_t r;
    r.we = we; r.addr = a; r.wdata = d;
    if (port) dbg_q.push_back(r);
    else cpu_q.push_back(r);
  endtask

  always begin : drv_cpu
    req_t r;
    @(posedge clk); #2;
    if (cpu_act && cpu_done_o) begin
      cpu_act = 1'b0; cpu_req_i = 1'b0;
    end
    if (!cpu_act && cpu_q.size() != 0) begin
      r = cpu_q.pop_front();
      cpu_we_i = r.we; cpu_addr_i = r.addr; cpu_wdata_i = r.wdata;
      cpu_req_i = 1'b1; cpu_act = 1'b1;
    end
  end

  always begin : drv_dbg
    req_t r;
    @(posedge clk); #2;
    if (dbg_act && dbg_done_o) begin
      dbg_act = 1'b0; dbg_req_i = 1'b0;
    end
    if (!dbg_act && dbg_q.size() != 0) begin
      r = dbg_q.pop_front();
      dbg_we_i = r.we; dbg_addr_i = r.addr; dbg_wdata_i = r.wdata;
      dbg_req_i = 1'b1; dbg_act = 1'b1;
    end
  end

  // ---------------- memory responder ----------------
  bit resp_en  = 1'b1;
  int resp_lat = 1;   // ack in the resp_lat-th cycle of mem_req_o; 0 = never
  int resp_age = 0;

  always begin : responder
    @(posedge clk); #2;
    if (resp_en) begin
      if (mem_ack_i) begin
        mem_ack_i = 1'b0; mem_rdata_i = NOISE; resp_age = 0;
      end else if (mem_req_o) begin
        resp_age++;
        if (resp_lat != 0 && resp_age >= resp_lat) begin
          mem_ack_i = 1'b1; mem_rdata_i = mem_data(mem_addr_o);
        end
      end else begin
        resp_age = 0;
      end
    end
  end

  // ---------------- transaction-level model ----------------
  bit          m_busy = 1'b0;
  bit          m_last = 1'b1;     // port served most recently
  bit          m_port = 1'b0;
  logic        m_we = 1'b0;
  logic [31:0] m_addr = '0, m_wdata = '0;
  int          m_age = 0;
  logic        e_cpu_done = 1'b0, e_dbg_done = 1'b0, e_err = 1'b0;
  logic [31:0] e_cpu_rdata = '0, e_dbg_rdata = '0;

  task automatic complete(input logic [31:0] data, input logic err);
    if (m_port) begin e_dbg_done = 1'b1; e_dbg_rdata = data; end
    else begin e_cpu_done = 1'b1; e_cpu_rdata = data; end
    e_err = err;
    m_busy = 1'b0;
  endtask

  // Predict the outputs after the coming rising edge from the inputs now stable.
  task automatic model_step();
    logic want_c, want_d;
    if (!rst_i) begin
      m_busy = 1'b0; m_last = 1'b1; m_age = 0;
      e_cpu_done = 1'b0; e_dbg_done = 1'b0; e_err = 1'b0;
      e_cpu_rdata = '0; e_dbg_rdata = '0;
    end else begin
      want_c = cpu_req_i && !e_cpu_done;
      want_d = dbg_req_i && !e_dbg_done;
      e_cpu_done = 1'b0; e_dbg_done = 1'b0; e_err = 1'b0;
      if (m_busy) begin
        if (mem_ack_i) complete(m_we ? 32'h0 : mem_data(m_addr), 1'b0);
        else if (TMO_ON && m_age == TIMEOUT - 1) complete(32'h0, 1'b1);
        else m_age++;
      end else if (want_c || want_d) begin
        m_port  = (want_c && want_d) ? ~m_last : want_d;
        m_we    = m_port ? dbg_we_i : cpu_we_i;
        m_addr  = m_port ? dbg_addr_i : cpu_addr_i;
        m_wdata = m_port ? dbg_wdata_i : cpu_wdata_i;
        m_last  = m_port;
        m_busy  = 1'b1;
        m_age   = 0;
      end
    end
  endtask

  // ---------------- compare process ----------------
  bit   chk_en = 1'b0;
  bit   log_en = 1'b0;
  bit   req_seen = 1'b0;
  logic [31:0] addr_log[$];
  bit   done_log[$];

  always @(negedge clk) begin
    if (chk_en) begin
      chk1("mem_req_o", mem_req_o, m_busy);
      chk1("busy_o", busy_o, m_busy);
      chk1("cpu_done_o", cpu_done_o, e_cpu_done);
      chk1("dbg_done_o", dbg_done_o, e_dbg_done);
      chk1("err_o", err_o, e_err);
      chk1("cpu_stall_o", cpu_stall_o, cpu_req_i & ~e_cpu_done);
      chk32("cpu_rdata_o", cpu_rdata_o, e_cpu_rdata);
      chk32("dbg_rdata_o", dbg_rdata_o, e_dbg_rdata);
      if (m_busy) begin
        chk1("mem_we_o", mem_we_o, m_we);
        chk32("mem_addr_o", mem_addr_o, m_addr);
        chk32("mem_wdata_o", mem_wdata_o, m_wdata);
      end
    end
    if (log_en) begin
      if (mem_req_o && !req_seen) addr_log.push_back(mem_addr_o);
      if (cpu_done_o) done_log.push_back(1'b0);
      if (dbg_done_o) done_log.push_back(1'b1);
    end
    req_seen = mem_req_o;
    model_step();
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int k);
    repeat (k) begin
      @(posedge clk); #3;
    end
  endtask

  task automatic wait_done(input bit port, input int limit, output int n);
    bit seen;
    seen = 1'b0;
    n = 0;
    while (!seen && n < limit) begin
      tick(1);
      n++;
      seen = port ? dbg_done_o : cpu_done_o;
    end
    chk1(port ? "wait dbg_done_o" : "wait cpu_done_o", seen, 1'b1);
  endtask

  task automatic wait_idle(input int limit);
    bit idle;
    int n;
    idle = 1'b0;
    n = 0;
    while (!idle && n < limit) begin
      tick(1);
      n++;
      idle = !busy_o && !cpu_act && !dbg_act && cpu_q.size() == 0 &&
             dbg_q.size() == 0 && !cpu_done_o && !dbg_done_o;
    end
    chk1("wait_idle", idle, 1'b1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    n_mis++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin : stim
    int n;
    logic [31:0] exp_addr[4];
    bit exp_ord2[4];
    bit exp_ord3[5];

    // Reset values.
    tick(2);
    chk_en = 1'b1;
    tick(1);
    chk1("rst mem_req_o", mem_req_o, 1'b0);
    chk1("rst busy_o", busy_o, 1'b0);
    chk1("rst err_o", err_o, 1'b0);
    chk1("rst cpu_done_o", cpu_done_o, 1'b0);
    chk32("rst mem_addr_o", mem_addr_o, 32'h0);
    chk32("rst cpu_rdata_o", cpu_rdata_o, 32'h0);
    chk32("rst dbg_rdata_o", dbg_rdata_o, 32'h0);
    rst_i = 1'b1;
    tick(1);

    // 1: CPU read 0x10, ack in the first BUSY cycle.
    push(1'b0, 1'b0, 32'h10, 32'h0);
    tick(1);
    chk1("t1 stall while pending", cpu_stall_o, 1'b1);
    wait_done(1'b0, 20, n);
    chk32("t1 req-to-done cycles", 32'(n), 32'd2);
    chk32("t1 cpu_rdata_o", cpu_rdata_o, 32'hDEAD_BEEF);
    wait_idle(20);
    push(1'b1, 1'b0, 32'h44, 32'h0);
    wait_idle(20);
    chk32("t1 dbg_rdata_o", dbg_rdata_o, 32'h5A5A_1155);

    // 2: two simultaneous write pairs, CPU wins both collisions.
    addr_log.delete(); done_log.delete(); log_en = 1'b1;
    push(1'b0, 1'b1, 32'h20, 32'h1234);
    push(1'b1, 1'b1, 32'h24, 32'h5678);
    wait_idle(40);
    push(1'b0, 1'b1, 32'h30, 32'hAAAA);
    push(1'b1, 1'b1, 32'h34, 32'hBBBB);
    wait_idle(40);
    log_en = 1'b0;
    exp_addr = '{32'h20, 32'h24, 32'h30, 32'h34};
    exp_ord2 = '{1'b0, 1'b1, 1'b0, 1'b1};
    chk32("t2 transaction count", 32'(addr_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < addr_log.size(); i++) chk32("t2 mem_addr_o order", addr_log[i], exp_addr[i]);
    for (int i = 0; i < 4 && i < done_log.size(); i++) chk1("t2 done order", done_log[i], exp_ord2[i]);
    chk32("t2 write cpu_rdata_o", cpu_rdata_o, 32'h0);

    // 3: continuous debug traffic, one CPU request slips in at the next arbitration.
    done_log.delete(); log_en = 1'b1;
    for (int i = 0; i < 4; i++) push(1'b1, 1'b0, 32'h100 + 32'(4 * i), 32'h0);
    tick(2);
    push(1'b0, 1'b0, 32'h200, 32'h0);
    wait_idle(80);
    log_en = 1'b0;
    exp_ord3 = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    chk32("t3 done count", 32'(done_log.size()), 32'd5);
    for (int i = 0; i < 5 && i < done_log.size(); i++) chk1("t3 done order", done_log[i], exp_ord3[i]);

    // Requester drops req mid-BUSY: transaction still completes.
    resp_lat = 3;
    push(1'b0, 1'b1, 32'h50, 32'hCAFE);
    tick(2);
    chk1("drop busy_o", busy_o, 1'b1);
    cpu_req_i = 1'b0;
    wait_done(1'b0, 20, n);
    chk32("drop busy-to-done cycles", 32'(n), 32'd3);
    wait_idle(20);
    resp_lat = 1;

    // 4: reset during BUSY, late ack is ignored.
    resp_en = 1'b0;
    push(1'b0, 1'b0, 32'h40, 32'h0);
    tick(2);
    chk1("t4 busy before reset", busy_o, 1'b1);
    rst_i = 1'b0; cpu_req_i = 1'b0; cpu_act = 1'b0;
    tick(1);
    rst_i = 1'b1;
    chk1("t4 mem_req_o after reset", mem_req_o, 1'b0);
    chk1("t4 busy_o after reset", busy_o, 1'b0);
    tick(2);
    mem_ack_i = 1'b1; mem_rdata_i = 32'h7777_7777;
    tick(1);
    mem_ack_i = 1'b0; mem_rdata_i = NOISE;
    chk1("t4 late ack no done", cpu_done_o, 1'b0);
    chk1("t4 late ack no busy", busy_o, 1'b0);
    chk32("t4 cpu_rdata_o", cpu_rdata_o, 32'h0);
    resp_en = 1'b1;
    tick(2);

`ifdef DMEM_ARB_TIMEOUT_EN
    // 5: no ack -> abort after TIMEOUT BUSY cycles; then ack on the expiry cycle.
    resp_lat = 0;
    push(1'b0, 1'b0, 32'h60, 32'h0);
    tick(1);
    wait_done(1'b0, 20, n);
    chk32("t5 abort req-to-done cycles", 32'(n), 32'd5);
    chk1("t5 err_o", err_o, 1'b1);
    chk32("t5 cpu_rdata_o", cpu_rdata_o, 32'h0);
    wait_idle(20);
    resp_lat = 4;
    push(1'b0, 1'b0, 32'h60, 32'h0);
    tick(1);
    wait_done(1'b0, 20, n);
    chk32("t5 late-ack req-to-done cycles", 32'(n), 32'd5);
    chk1("t5 ack wins err_o", err_o, 1'b0);
    chk32("t5 ack wins cpu_rdata_o", cpu_rdata_o, 32'h5A5A_1171);
    wait_idle(20);
    resp_lat = 1;
`else
    // 6: no ack for 50 cycles -> stays BUSY, no error.
    resp_lat = 0;
    push(1'b0, 1'b0, 32'h60, 32'h0);
    tick(1);
    tick(50);
    chk1("t6 busy_o", busy_o, 1'b1);
    chk1("t6 mem_req_o", mem_req_o, 1'b1);
    chk1("t6 err_o", err_o, 1'b0);
    rst_i = 1'b0; cpu_req_i = 1'b0; cpu_act = 1'b0;
    tick(1);
    rst_i = 1'b1;
    chk1("t6 busy_o after reset", busy_o, 1'b0);
    resp_lat = 1;
    tick(2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
